// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared constants and sizing helpers for the 3x3 streaming convolution filter
package conv3x3_pkg;
  localparam int NTAP = 9;
  localparam int ROW_W = 12;
  localparam int IDX_TL = 0, IDX_TC = 1, IDX_TR = 2;
  localparam int IDX_ML = 3, IDX_C = 4, IDX_MR = 5;
  localparam int IDX_BL = 6, IDX_BC = 7, IDX_BR = 8;
  localparam int DEF_KERNEL [NTAP] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  function automatic int sum_w(input int pix_w, input int coef_w);
    return pix_w + coef_w + 4;
  endfunction
endpackage

// File: rtl/conv3x3_stream_filter_if.sv
// conv3x3_stream_filter_if: pixel stream, coefficient write port and filtered result bundle
interface conv3x3_stream_filter_if #(parameter int PIX_W = 10, parameter int COEF_W = 4);
  logic                     IN_VALID;
  logic [PIX_W-1:0]         IN_PIX;
  logic                     IN_SOF;
  logic                     COEF_WE;
  logic [3:0]               COEF_ADDR;
  logic signed [COEF_W-1:0] COEF_DATA;
  logic                     OUT_VALID;
  logic [PIX_W-1:0]         OUT_PIX;
  logic                     OUT_BORDER;
  modport master (output IN_VALID, IN_PIX, IN_SOF, COEF_WE, COEF_ADDR, COEF_DATA,
                  input  OUT_VALID, OUT_PIX, OUT_BORDER);
  modport slave  (input  IN_VALID, IN_PIX, IN_SOF, COEF_WE, COEF_ADDR, COEF_DATA,
                  output OUT_VALID, OUT_PIX, OUT_BORDER);
endinterface

// File: rtl/conv3x3_line_buffer.sv
// conv3x3_line_buffer: one-line pixel delay advancing only on enabled cycles; contents survive reset
module conv3x3_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_ptr;
  assign o_data = r_mem[r_ptr];
  // circular pointer; only the pointer is reset so stale data stays and is masked downstream
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (i_en) r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  // read-before-write: the slot read this cycle holds the pixel from one line ago
  always_ff @(posedge clk)
    if (i_en) r_mem[r_ptr] <= i_data;
endmodule

// File: rtl/conv3x3_stream_filter.sv
// conv3x3_stream_filter: 3x3 streaming convolution with double-buffered kernel, 3-cycle pipeline;
// define CONV3X3_STREAM_FILTER_ABS_EN for magnitude mode (abs after shift, before clamp)
module conv3x3_stream_filter
  import conv3x3_pkg::*;
#(
  parameter int PIX_W  = 10,
  parameter int LINE_W = 640,
  parameter int COEF_W = 4,
  parameter int SHIFT  = 0
) (
  input logic CLK,
  input logic RST,
  conv3x3_stream_filter_if.slave bus
);
  localparam int SW = sum_w(PIX_W, COEF_W);
  localparam int CW = $clog2(LINE_W);
  logic [CW-1:0]            r_col, w_col;
  logic [ROW_W-1:0]         r_row, w_row;
  logic                     w_sof, w_eol;
  logic signed [COEF_W-1:0] r_shadow [NTAP];
  logic signed [COEF_W-1:0] r_active [NTAP];
  logic signed [COEF_W-1:0] w_shadow_nx [NTAP];
  logic signed [COEF_W-1:0] w_coef [NTAP];
  logic [PIX_W-1:0]         w_tap1, w_tap0;
  logic [PIX_W-1:0]         w_new [3];
  logic [PIX_W-1:0]         r_win [3][2];
  logic [PIX_W-1:0]         w_win [3][3];
  logic signed [SW-1:0]     w_prod [NTAP];
  logic signed [SW-1:0]     r_prod [NTAP];
  logic signed [SW-1:0]     w_sum, r_sum, w_sh, w_val;
  logic [PIX_W-1:0]         w_clip;
  logic                     r_v1, r_v2, r_b1, r_b2;
  assign w_sof = bus.IN_VALID & bus.IN_SOF;
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;
  assign w_eol = w_col == CW'(LINE_W - 1);
  // position of the next pixel; row saturates instead of wrapping
  always_ff @(posedge CLK)
    if (RST) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.IN_VALID) begin
      r_col <= w_eol ? '0 : w_col + 1'b1;
      r_row <= (w_eol && !(&w_row)) ? w_row + 1'b1 : w_row;
    end
  // a write coinciding with SOF is merged into the bank that SOF pixel already uses
  always_comb
    for (int k = 0; k < NTAP; k++) begin
      w_shadow_nx[k] = (bus.COEF_WE && bus.COEF_ADDR == 4'(k)) ? bus.COEF_DATA : r_shadow[k];
      w_coef[k]      = w_sof ? w_shadow_nx[k] : r_active[k];
    end
  // shadow bank takes writes, active bank snapshots it at each start of frame
  always_ff @(posedge CLK)
    if (RST)
      for (int k = 0; k < NTAP; k++) begin
        r_shadow[k] <= COEF_W'(DEF_KERNEL[k]);
        r_active[k] <= COEF_W'(DEF_KERNEL[k]);
      end
    else begin
      r_shadow <= w_shadow_nx;
      if (w_sof) r_active <= w_shadow_nx;
    end
  conv3x3_line_buffer #(.DEPTH(LINE_W), .W(PIX_W)) u_lb0 (
    .clk(CLK), .rst(RST), .i_en(bus.IN_VALID), .i_data(bus.IN_PIX), .o_data(w_tap1)
  );
  conv3x3_line_buffer #(.DEPTH(LINE_W), .W(PIX_W)) u_lb1 (
    .clk(CLK), .rst(RST), .i_en(bus.IN_VALID), .i_data(w_tap1), .o_data(w_tap0)
  );
  // window rows top..bottom = rows r-2..r, columns left..right = c-2..c, current pixel included
  always_comb begin
    w_new[0] = w_tap0;
    w_new[1] = w_tap1;
    w_new[2] = bus.IN_PIX;
    for (int i = 0; i < 3; i++) begin
      w_win[i][0] = r_win[i][0];
      w_win[i][1] = r_win[i][1];
      w_win[i][2] = w_new[i];
      for (int j = 0; j < 3; j++)
        w_prod[3*i+j] = SW'($signed({1'b0, w_win[i][j]})) * SW'(w_coef[3*i+j]);
    end
  end
  // horizontal shift of the two older window columns
  always_ff @(posedge CLK)
    if (bus.IN_VALID)
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= w_new[i];
      end
  // stage valids; reset drops everything in flight
  always_ff @(posedge CLK)
    if (RST) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= bus.IN_VALID;
      r_v2 <= r_v1;
    end
  // stage 1 products and stage 2 sum; border flag travels alongside
  always_ff @(posedge CLK) begin
    r_prod <= w_prod;
    r_b1   <= (w_row < ROW_W'(2)) || (w_col < CW'(2));
    r_sum  <= w_sum;
    r_b2   <= r_b1;
  end
  // full-precision sum, shift, optional magnitude, clamp to pixel range
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAP; k++) w_sum = w_sum + r_prod[k];
    w_sh = r_sum >>> SHIFT;
`ifdef CONV3X3_STREAM_FILTER_ABS_EN
    w_val = w_sh[SW-1] ? -w_sh : w_sh;
`else
    w_val = w_sh;
`endif
    w_clip = w_val[SW-1] ? '0 : (|w_val[SW-2:PIX_W]) ? '1 : w_val[PIX_W-1:0];
  end
  // stage 3 result register
  always_ff @(posedge CLK)
    if (RST) begin
      bus.OUT_VALID  <= 1'b0;
      bus.OUT_PIX    <= '0;
      bus.OUT_BORDER <= 1'b0;
    end else begin
      bus.OUT_VALID <= r_v2;
      if (r_v2) begin
        bus.OUT_BORDER <= r_b2;
        bus.OUT_PIX    <= r_b2 ? '0 : w_clip;
      end
    end
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// tb_conv3x3_stream_filter: random and directed frames checked against a frame-array reference model
module tb_conv3x3_stream_filter;
  localparam int PW = 10, LW = 8, CWID = 4, SH = 0, NR = 16;
  localparam int PMAX = (1 << PW) - 1;
  localparam int DEF [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  typedef struct {int stamp; int b; int p;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  conv3x3_stream_filter_if #(.PIX_W(PW), .COEF_W(CWID)) bus();
  conv3x3_stream_filter #(.PIX_W(PW), .LINE_W(LW), .COEF_W(CWID), .SHIFT(SH)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  exp_t q[$];
  exp_t m_e;
  int n_cmp = 0, n_err = 0, cyc = 0, last_nb = -1;
  int img [NR][LW];
  int m_sh [9], m_act [9];
  int mr = 0, mc = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int model_pix();
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += img[(mr - 2 + i) % NR][mc - 2 + j] * m_act[3*i+j];
    s = s >>> SH;
`ifdef CONV3X3_STREAM_FILTER_ABS_EN
    if (s < 0) s = -s;
`endif
    return s < 0 ? 0 : (s > PMAX ? PMAX : s);
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (bus.OUT_VALID) begin
        if (q.size() == 0) check("spurious_valid", 1, 0);
        else begin
          m_e = q.pop_front();
          check("latency", cyc - m_e.stamp, 3);
          check("border", int'(bus.OUT_BORDER), m_e.b);
          check("pix", int'(bus.OUT_PIX), m_e.p);
          if (m_e.b == 0) last_nb = int'(bus.OUT_PIX);
        end
      end else if (q.size() != 0 && cyc - q[0].stamp >= 3) begin
        check("missing_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  task automatic drive(input bit v, input int pix, input bit sof, input bit we, input int addr, input int data);
    exp_t e;
    bus.IN_VALID = v;
    bus.IN_PIX = PW'(pix);
    bus.IN_SOF = sof;
    bus.COEF_WE = we;
    bus.COEF_ADDR = 4'(addr);
    bus.COEF_DATA = CWID'(data);
    if (we && addr <= 8) m_sh[addr] = data;
    if (v) begin
      if (sof) begin
        m_act = m_sh;
        mr = 0;
        mc = 0;
      end
      img[mr % NR][mc] = pix;
      e.stamp = cyc;
      e.b = (mr < 2 || mc < 2) ? 1 : 0;
      e.p = e.b ? 0 : model_pix();
      q.push_back(e);
      if (mc == LW - 1) begin
        mc = 0;
        mr++;
      end else mc++;
    end
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    bus.IN_SOF = 1'b0;
    bus.COEF_WE = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic write_kernel(input int k [9]);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, i, k[i]);
  endtask
  function automatic int rand_coef();
    return int'($urandom_range(15)) - 8;
  endfunction
  task automatic random_kernel();
    int k [9];
    for (int i = 0; i < 9; i++) k[i] = rand_coef();
    write_kernel(k);
  endtask
  task automatic frame(input int rows, input int mode, input int val, input int bub, input bit sof);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LW; c++) begin
        while (bub > 0 && int'($urandom_range(99)) < bub) drive(0, 0, 0, 0, 0, 0);
        drive(1, mode == 0 ? val : (mode == 1 ? 10 * r : int'($urandom_range(PMAX))),
              sof && r == 0 && c == 0, 0, 0, 0);
      end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mr = 0;
    mc = 0;
    m_sh = DEF;
    m_act = DEF;
    check("rst_valid", int'(bus.OUT_VALID), 0);
    check("rst_pix", int'(bus.OUT_PIX), 0);
    check("rst_border", int'(bus.OUT_BORDER), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    bus.IN_VALID = 1'b0;
    bus.IN_PIX = '0;
    bus.IN_SOF = 1'b0;
    bus.COEF_WE = 1'b0;
    bus.COEF_ADDR = '0;
    bus.COEF_DATA = '0;
    m_sh = DEF;
    m_act = DEF;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    frame(6, 0, 100, 0, 1);
    idle(5);
    check("const_nb", last_nb, 0);
    frame(8, 1, 0, 0, 1);
    idle(5);
    check("ramp_nb", last_nb, 80);
    write_kernel('{1, 2, 1, 0, 0, 0, -1, -2, -1});
    frame(8, 1, 0, 0, 1);
    idle(5);
`ifdef CONV3X3_STREAM_FILTER_ABS_EN
    check("ramp_neg_nb", last_nb, 80);
`else
    check("ramp_neg_nb", last_nb, 0);
`endif
    write_kernel('{1, 1, 1, 1, 1, 1, 1, 1, 1});
    frame(5, 0, 1023, 0, 1);
    idle(5);
    check("sat_nb", last_nb, 1023);
    frame(3, 2, 0, 0, 1);
    write_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
    frame(3, 2, 0, 0, 0);
    frame(4, 2, 0, 0, 1);
    idle(5);
    drive(0, 0, 0, 1, 9, 7);
    drive(0, 0, 0, 1, 12, -8);
    drive(0, 0, 0, 1, 15, 5);
    frame(4, 2, 0, 0, 1);
    idle(5);
    for (int t = 0; t < 3; t++) begin
      random_kernel();
      drive(1, int'($urandom_range(PMAX)), 1, 1, int'($urandom_range(8)), rand_coef());
      for (int c = 1; c < LW; c++) drive(1, int'($urandom_range(PMAX)), 0, 0, 0, 0);
      frame(5, 2, 0, 50, 0);
      idle(5);
    end
    random_kernel();
    frame(3, 2, 0, 0, 1);
    for (int c = 0; c < 4; c++) drive(1, int'($urandom_range(PMAX)), 0, 0, 0, 0);
    do_reset();
    frame(4, 2, 0, 30, 0);
    frame(3, 2, 0, 0, 1);
    idle(6);
    check("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
